// File: rtl/sci_master.sv
// sci_master: round-robin arbiter and serialiser for the SCI register-access link.
// One frame is in flight at a time; each one ends with a one-cycle DONE pulse carrying read data or an abort flag.
module sci_master #(
    parameter int NUM_REQ    = 3,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 255
) (
    input  logic                          CLK,
    input  logic                          RSTN,
    input  logic [NUM_REQ-1:0]            REQ,
    input  logic [NUM_REQ-1:0]            REQ_WNR,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] REQ_ADDR,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_WDATA,
    output logic [NUM_REQ-1:0]            DONE,
    output logic [DATA_WIDTH-1:0]         RDATA,
    output logic                          ERR,
    output logic                          CSN,
    output logic                          SIN,
    input  logic                          SOUT,
    input  logic                          SACK
);
    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int SHIFT_W = ADDR_WIDTH + DATA_WIDTH;
    localparam int CNT_MAX = (TIMEOUT > ADDR_WIDTH)
                           ? ((TIMEOUT > DATA_WIDTH) ? TIMEOUT : DATA_WIDTH)
                           : ((ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_WDATA,
        S_WAIT_ACK,
        S_RDATA,
        S_GAP
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [IDX_W-1:0]      r_ptr;
    logic [IDX_W-1:0]      r_grant;
    logic                  r_wnr;
    logic [SHIFT_W-1:0]    r_shift;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_cnt_next;
    logic [DATA_WIDTH-1:0] r_rx;
    logic [DATA_WIDTH-1:0] w_rx_next;
    logic                  r_abort;
    logic                  w_abort_next;
    logic                  r_csn;
    logic                  r_sin;
    logic [NUM_REQ-1:0]    r_done;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_err;

    logic                  w_grant_valid;
    logic [IDX_W-1:0]      w_grant_idx;
    logic                  w_frame_next;

    logic [ADDR_WIDTH-1:0] w_addr  [NUM_REQ];
    logic [DATA_WIDTH-1:0] w_wdata [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign w_addr[gi]  = REQ_ADDR[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign w_wdata[gi] = REQ_WDATA[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // Walk offsets from farthest to nearest so the first requester after the pointer wins.
    always_comb begin
        int v_idx;
        w_grant_valid = 1'b0;
        w_grant_idx   = '0;
        v_idx         = 0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            v_idx = int'(r_ptr) + k;
            if (v_idx >= NUM_REQ) begin
                v_idx = v_idx - NUM_REQ;
            end
            if (REQ[v_idx]) begin
                w_grant_valid = 1'b1;
                w_grant_idx   = IDX_W'(v_idx);
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_rx_next    = r_rx;
        w_abort_next = r_abort;
        case (r_state)
            S_IDLE: begin
                w_cnt_next = '0;
                if (w_grant_valid) begin
                    w_state_next = S_CMD;
                    w_rx_next    = '0;
                    w_abort_next = 1'b0;
                end
            end
            S_CMD: begin
                w_state_next = S_ADDR;
                w_cnt_next   = '0;
            end
            S_ADDR: begin
                if (r_cnt == CNT_W'(ADDR_WIDTH - 1)) begin
                    w_cnt_next   = '0;
                    w_state_next = r_wnr ? S_WDATA : S_WAIT_ACK;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            S_WDATA: begin
                if (r_cnt == CNT_W'(DATA_WIDTH - 1)) begin
                    w_cnt_next   = '0;
                    w_state_next = S_GAP;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            S_WAIT_ACK: begin
                // SACK takes priority over the timeout in the final wait cycle.
                if (SACK) begin
                    w_rx_next    = (r_rx << 1) | DATA_WIDTH'(SOUT);
                    w_cnt_next   = CNT_W'(1);
                    w_state_next = (DATA_WIDTH == 1) ? S_GAP : S_RDATA;
                end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                    w_abort_next = 1'b1;
                    w_state_next = S_GAP;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            S_RDATA: begin
                if (SACK) begin
                    w_rx_next = (r_rx << 1) | DATA_WIDTH'(SOUT);
                    if (r_cnt == CNT_W'(DATA_WIDTH - 1)) begin
                        w_state_next = S_GAP;
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end else begin
                    w_abort_next = 1'b1;
                    w_state_next = S_GAP;
                end
            end
            S_GAP: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // CSN/SIN are registered from the next state so the link pins come straight off flops.
    assign w_frame_next = (w_state_next == S_CMD)      || (w_state_next == S_ADDR) ||
                          (w_state_next == S_WDATA)    || (w_state_next == S_WAIT_ACK) ||
                          (w_state_next == S_RDATA);

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            r_state <= S_IDLE;
            r_ptr   <= IDX_W'(NUM_REQ - 1);
            r_grant <= '0;
            r_wnr   <= 1'b0;
            r_shift <= '0;
            r_cnt   <= '0;
            r_rx    <= '0;
            r_abort <= 1'b0;
            r_csn   <= 1'b1;
            r_sin   <= 1'b0;
            r_done  <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_rx    <= w_rx_next;
            r_abort <= w_abort_next;
            r_csn   <= !w_frame_next;
            r_done  <= '0;

            if (r_state == S_IDLE && w_grant_valid) begin
                r_ptr   <= w_grant_idx;
                r_grant <= w_grant_idx;
                r_wnr   <= REQ_WNR[w_grant_idx];
                r_shift <= {w_addr[w_grant_idx], w_wdata[w_grant_idx]};
                r_sin   <= REQ_WNR[w_grant_idx];
            end else if (w_state_next == S_ADDR || w_state_next == S_WDATA) begin
                r_sin   <= r_shift[SHIFT_W-1];
                r_shift <= r_shift << 1;
            end else begin
                r_sin <= 1'b0;
            end

            if (w_state_next == S_GAP) begin
                r_done  <= NUM_REQ'(1) << r_grant;
                r_rdata <= w_abort_next ? '0 : w_rx_next;
                r_err   <= w_abort_next;
            end
        end
    end

    assign DONE  = r_done;
    assign RDATA = r_rdata;
    assign ERR   = r_err;
    assign CSN   = r_csn;
    assign SIN   = r_sin;

endmodule
